roc_stream_encoder: RTL and testbench

- Transmit-side counterpart of the deser400 header detector.
- Serialises TBM header, TBM trailer and ROC header frames into the 2-bit-per-clock symbol stream that the deser400 receive path consumes: idle ones, 9-bit leader, 3-bit id, payload nibbles.
- Used as a DTB-internal pattern source and loopback stimulus for the deser400 receive path.
- Optional 1-bit phase shift exercises both receiver alignment modes.

---
 rtl/roc_stream_encoder.sv | 238 +++++++++++++++++++++++
 tb/tb_roc_stream_encoder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/roc_stream_encoder.sv
// roc_stream_encoder
//
// Transmit-side pattern source for the deser400 receive path. Serialises
// TBM header, TBM trailer and ROC header frames into a 2-bit-per-clock
// symbol stream. Each frame is a 9-bit leader (0_11111111), a 3-bit id and
// cmd_len payload nibbles, followed by at least GAP idle clocks of ones.
// The phase input can delay the whole stream by one bit so that both
// receiver alignment modes can be exercised.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   frame request handshake (ready only in IDLE)
//   cmd_type              0 ROC header, 1 TBM header, 2 TBM trailer, 3 as 0
//   cmd_stat              ROC status bits, id[1:0] of a ROC header
//   cmd_len               payload nibble count (0 allowed)
//   din_valid/din_ready   payload nibble handshake, din is the nibble
//   phase                 0 even alignment, 1 stream delayed by one bit
//   tx                    symbol pair, tx[1] is the earlier bit
//   busy                  high whenever not in IDLE
//   underrun              sticky, a payload nibble was missing when due
//
// Optional feature, enabled by defining DESER400_TX_ERRINJ_EN:
//   inj_err   a pulse arms a one-shot corruption of the next frame's leader
//   inj_done  one-clock pulse on the last HDR pair of the corrupted frame

module roc_stream_encoder #(
  parameter int GAP   = 2,
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_type,
  input  logic [1:0]       cmd_stat,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [3:0]       din,
  input  logic             phase,
  output logic [1:0]       tx,
  output logic             busy,
  output logic             underrun
`ifdef DESER400_TX_ERRINJ_EN
  ,
  input  logic             inj_err,
  output logic             inj_done
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             half_q, half_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [3:0]       nib_q, nib_d;
  logic [2:0]       id_q, id_d;
  logic             phase_q, phase_d;
  logic             held_q, held_d;
  logic [1:0]       tx_q, tx_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             din_ready_q, din_ready_d;
  logic             busy_q, busy_d;
  logic             underrun_q, underrun_d;
  logic             err_cur_d;
  logic [1:0]       pair;

`ifdef DESER400_TX_ERRINJ_EN
  logic arm_q, arm_d;
  logic err_cur_q;
  logic inj_done_q, inj_done_d;
`endif

  // Next-state logic. All registered outputs are computed from the next
  // state so that tx, din_ready, busy and cmd_ready line up with state_q
  // (the first header pair appears the clock after cmd accept).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    half_d     = half_q;
    len_d      = len_q;
    nib_d      = nib_q;
    id_d       = id_q;
    phase_d    = phase_q;
    underrun_d = underrun_q;
`ifdef DESER400_TX_ERRINJ_EN
    arm_d      = arm_q | inj_err;
    err_cur_d  = err_cur_q;
`else
    err_cur_d  = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cmd_ready_q && cmd_valid) begin
          state_d    = ST_HDR;
          cnt_d      = 4'd0;
          len_d      = cmd_len;
          phase_d    = phase;
          underrun_d = 1'b0;
          case (cmd_type)
            2'd1:    id_d = 3'b100;
            2'd2:    id_d = 3'b110;
            default: id_d = {1'b0, cmd_stat};
          endcase
`ifdef DESER400_TX_ERRINJ_EN
          err_cur_d = arm_q | inj_err;
          arm_d     = 1'b0;
`endif
        end
      end
      ST_HDR: begin
        if (cnt_q == 4'd5) begin
          half_d = 1'b0;
          state_d = (len_q == '0) ? ST_GAP : ST_DATA;
          cnt_d   = 4'd0;
`ifdef DESER400_TX_ERRINJ_EN
          err_cur_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DATA: begin
        if (!half_q) begin
          half_d = 1'b1;
        end else if (len_q == '0) begin
          state_d = ST_GAP;
          cnt_d   = 4'd0;
        end else begin
          half_d = 1'b0;
        end
      end
      default: begin
        if (cnt_q == 4'(GAP - 1)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    endcase

    // A missing nibble is replaced by all ones; the frame keeps its length.
    if (din_ready_q) begin
      len_d = len_q - LEN_W'(1);
      if (din_valid) begin
        nib_d = din;
      end else begin
        nib_d      = 4'hF;
        underrun_d = 1'b1;
      end
    end

    case (state_d)
      ST_HDR: begin
        case (cnt_d)
          4'd0:    pair = 2'b01;
          4'd4:    pair = {~err_cur_d, id_d[2]};
          4'd5:    pair = id_d[1:0];
          default: pair = 2'b11;
        endcase
      end
      ST_DATA: pair = half_d ? nib_d[1:0] : nib_d[3:2];
      default: pair = 2'b11;
    endcase

    // Odd alignment shifts the stream by one bit through held_q.
    tx_d        = phase_d ? {held_q, pair[1]} : pair;
    held_d      = pair[0];
    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    din_ready_d = (len_d != '0) &&
                  (((state_d == ST_HDR) && (cnt_d == 4'd5)) ||
                   ((state_d == ST_DATA) && half_d));
`ifdef DESER400_TX_ERRINJ_EN
    inj_done_d  = (state_d == ST_HDR) && (cnt_d == 4'd5) && err_cur_d;
`endif
  end

  // State and output registers; reset forces an idle line immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      half_q      <= 1'b0;
      len_q       <= '0;
      nib_q       <= 4'hF;
      id_q        <= 3'b000;
      phase_q     <= 1'b0;
      held_q      <= 1'b1;
      tx_q        <= 2'b11;
      cmd_ready_q <= 1'b0;
      din_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
`ifdef DESER400_TX_ERRINJ_EN
      arm_q       <= 1'b0;
      err_cur_q   <= 1'b0;
      inj_done_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      half_q      <= half_d;
      len_q       <= len_d;
      nib_q       <= nib_d;
      id_q        <= id_d;
      phase_q     <= phase_d;
      held_q      <= held_d;
      tx_q        <= tx_d;
      cmd_ready_q <= cmd_ready_d;
      din_ready_q <= din_ready_d;
      busy_q      <= busy_d;
      underrun_q  <= underrun_d;
`ifdef DESER400_TX_ERRINJ_EN
      arm_q       <= arm_d;
      err_cur_q   <= err_cur_d;
      inj_done_q  <= inj_done_d;
`endif
    end
  end

  assign tx        = tx_q;
  assign cmd_ready = cmd_ready_q;
  assign din_ready = din_ready_q;
  assign busy      = busy_q;
  assign underrun  = underrun_q;
`ifdef DESER400_TX_ERRINJ_EN
  assign inj_done  = inj_done_q;
`endif

endmodule

// File: tb/tb_roc_stream_encoder.sv
// tb_roc_stream_encoder
//
// Directed bench for roc_stream_encoder. Stimulus pushes the hand-computed
// tx pair sequence of each frame into a scoreboard queue at cmd accept; a
// monitor pops one pair per clock and otherwise expects an idle line.
// Define DESER400_TX_ERRINJ_EN to include the error-injection scenario.

module tb_roc_stream_encoder;

  localparam int GAP   = 2;
  localparam int LEN_W = 5;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_type;
  logic [1:0]       cmd_stat;
  logic [LEN_W-1:0] cmd_len;
  logic             din_valid;
  logic             din_ready;
  logic [3:0]       din;
  logic             phase;
  logic [1:0]       tx;
  logic             busy;
  logic             underrun;
`ifdef DESER400_TX_ERRINJ_EN
  logic             inj_err;
  logic             inj_done;
`endif

  int         tests_run    = 0;
  int         tests_failed = 0;
  logic [1:0] pend_q[$];
  logic [1:0] exp_q[$];
  logic [3:0] din_q[$];
  logic [1:0] exp_pair;
  bit         starve = 1'b0;
  bit         mon_en = 1'b0;
  int         dr_cnt = 0;
  int         done_cnt = 0;

  roc_stream_encoder #(.GAP(GAP), .LEN_W(LEN_W)) dut (
`ifdef DESER400_TX_ERRINJ_EN
    .inj_err   (inj_err),
    .inj_done  (inj_done),
`endif
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_type  (cmd_type),
    .cmd_stat  (cmd_stat),
    .cmd_len   (cmd_len),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .din       (din),
    .phase     (phase),
    .tx        (tx),
    .busy      (busy),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  // One comparison; reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Queue the first count pairs of an npairs-long bit string, MSB first.
  task automatic pushBits(input logic [63:0] bits, input int npairs,
                          input int count);
    for (int i = 0; i < count; i++)
      pend_q.push_back(bits[2*(npairs-i)-1 -: 2]);
  endtask

  // Wait for cmd_ready, issue one command and hand its expected pairs to
  // the scoreboard right after the accept edge.
  task automatic applyStimulus(input logic [1:0] typ, input logic [1:0] stat,
                               input logic [LEN_W-1:0] len, input logic ph);
    int w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) checkOutput("cmd_ready_timeout", 32'd0, 32'd1);
    cmd_valid = 1'b1;
    cmd_type  = typ;
    cmd_stat  = stat;
    cmd_len   = len;
    phase     = ph;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
  endtask

  task automatic waitIdle(input string name);
    int w = 0;
    while ((exp_q.size() > 0 || !cmd_ready) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) checkOutput({name, "_idle_timeout"}, 32'd0, 32'd1);
  endtask

  // Monitor: compares tx against the scoreboard every clock.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && reset_n) begin
        if (din_ready) dr_cnt++;
`ifdef DESER400_TX_ERRINJ_EN
        if (inj_done) done_cnt++;
`endif
        if (exp_q.size() > 0) begin
          exp_pair = exp_q.pop_front();
          checkOutput("tx_frame", {30'd0, tx}, {30'd0, exp_pair});
        end else begin
          checkOutput("tx_idle", {30'd0, tx}, 32'd3);
        end
      end
    end
  end

  // Payload feeder: answers each din_ready with the next queued nibble.
  initial begin
    din_valid = 1'b0;
    din       = 4'h0;
    forever begin
      @(negedge clk);
      if (din_ready && !starve && din_q.size() > 0) begin
        din_valid = 1'b1;
        din       = din_q.pop_front();
      end else begin
        din_valid = 1'b0;
        din       = 4'h0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_type  = 2'd0;
    cmd_stat  = 2'd0;
    cmd_len   = '0;
    phase     = 1'b0;
`ifdef DESER400_TX_ERRINJ_EN
    inj_err   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_tx", {30'd0, tx}, 32'd3);
    checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    checkOutput("rst_din_ready", {31'd0, din_ready}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_underrun", {31'd0, underrun}, 32'd0);
    #1;
    reset_n = 1'b1;
    #1;
    checkOutput("rel_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    checkOutput("rel_cmd_ready_high", {31'd0, cmd_ready}, 32'd1);
    mon_en = 1'b1;

    // TBM header, payload A,B,C,D, even alignment.
    dr_cnt = 0;
    din_q.push_back(4'hA); din_q.push_back(4'hB);
    din_q.push_back(4'hC); din_q.push_back(4'hD);
    pushBits(64'h7FCABCD, 14, 14);
    applyStimulus(2'd1, 2'd0, 5'd4, 1'b0);
    waitIdle("tbm_hdr");
    checkOutput("tbm_hdr_din_ready_count", dr_cnt, 32'd4);

    // ROC header, stat 10, no payload; a cmd_valid while busy is ignored.
    dr_cnt = 0;
    pushBits(64'h7FA, 6, 6);
    applyStimulus(2'd0, 2'b10, 5'd0, 1'b0);
    repeat (2) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_type  = 2'd1;
    cmd_len   = 5'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3 + GAP) @(negedge clk);
    checkOutput("roc_busy_last", {31'd0, busy}, 32'd1);
    @(negedge clk);
    checkOutput("roc_busy_done", {31'd0, busy}, 32'd0);
    checkOutput("roc_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("roc_din_ready_count", dr_cnt, 32'd0);

    // Same TBM header with odd alignment: stream delayed by one bit.
    dr_cnt = 0;
    din_q.push_back(4'hA); din_q.push_back(4'hB);
    din_q.push_back(4'hC); din_q.push_back(4'hD);
    pushBits({34'd0, 1'b1, 28'h7FCABCD, 1'b1}, 15, 15);
    applyStimulus(2'd1, 2'd0, 5'd4, 1'b1);
    waitIdle("tbm_phase1");
    checkOutput("phase1_din_ready_count", dr_cnt, 32'd4);

    // TBM trailer with two missing nibbles.
    dr_cnt = 0;
    starve = 1'b1;
    pushBits(64'h7FEFF, 10, 10);
    applyStimulus(2'd2, 2'd0, 5'd2, 1'b0);
    waitIdle("trailer");
    starve = 1'b0;
    checkOutput("trailer_underrun", {31'd0, underrun}, 32'd1);
    checkOutput("trailer_din_ready_count", dr_cnt, 32'd2);

    // Reserved type encodes as ROC header; accept clears underrun.
    din_q.push_back(4'h5);
    pushBits(64'h7F95, 8, 8);
    applyStimulus(2'd3, 2'b01, 5'd1, 1'b0);
    checkOutput("underrun_cleared", {31'd0, underrun}, 32'd0);
    waitIdle("reserved");

    // Reset during the second payload nibble.
    din_q.push_back(4'hA); din_q.push_back(4'hB);
    din_q.push_back(4'hC); din_q.push_back(4'hD);
    pushBits(64'h7FCABCD, 14, 9);
    applyStimulus(2'd1, 2'd0, 5'd4, 1'b0);
    repeat (9) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_tx", {30'd0, tx}, 32'd3);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_din_ready", {31'd0, din_ready}, 32'd0);
    din_q.delete();
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    #1;
    checkOutput("midrst_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    checkOutput("midrst_cmd_ready_high", {31'd0, cmd_ready}, 32'd1);

    // Clean frame after reset: ROC header stat 11, one nibble 3.
    din_q.push_back(4'h3);
    pushBits(64'h7FB3, 8, 8);
    applyStimulus(2'd0, 2'b11, 5'd1, 1'b0);
    waitIdle("post_reset");

`ifdef DESER400_TX_ERRINJ_EN
    // Armed frame loses its last leader bit; the next frame is intact.
    done_cnt = 0;
    @(negedge clk);
    inj_err = 1'b1;
    @(negedge clk);
    inj_err = 1'b0;
    pushBits(64'h7F0, 6, 6);
    applyStimulus(2'd0, 2'b00, 5'd0, 1'b0);
    waitIdle("errinj");
    checkOutput("inj_done_count", done_cnt, 32'd1);
    pushBits(64'h7F8, 6, 6);
    applyStimulus(2'd0, 2'b00, 5'd0, 1'b0);
    waitIdle("errinj_next");
    checkOutput("inj_done_once", done_cnt, 32'd1);
`endif

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
